// File: rtl/rns_reg_file.sv
// Multi-domain register file: NUM_DOMAINS lanes per entry, three registered read ports,
// two masked write ports (port B wins per lane), post-reset hardware clear.
// Optional same-edge write-to-read forwarding is enabled by defining RNS_REGFILE_BYPASS_EN.
module rns_reg_file #(
    parameter int unsigned NUM_DOMAINS = 1,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_REGS    = 8,
    localparam int unsigned ADDR_W     = $clog2(NUM_REGS),
    localparam int unsigned W          = NUM_DOMAINS * DATA_W
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [ADDR_W-1:0]      rd_addr1_i,
    input  logic [ADDR_W-1:0]      rd_addr2_i,
    input  logic [ADDR_W-1:0]      rd_addr3_i,
    output logic [W-1:0]           rd_data1_o,
    output logic [W-1:0]           rd_data2_o,
    output logic [W-1:0]           rd_data3_o,
    input  logic                   wra_en_i,
    input  logic [ADDR_W-1:0]      wra_addr_i,
    input  logic [W-1:0]           wra_data_i,
    input  logic [NUM_DOMAINS-1:0] wra_mask_i,
    input  logic                   wrb_en_i,
    input  logic [ADDR_W-1:0]      wrb_addr_i,
    input  logic [W-1:0]           wrb_data_i,
    input  logic [NUM_DOMAINS-1:0] wrb_mask_i,
    output logic                   busy_o
);

    typedef enum logic {StInit, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]      mem_q [NUM_REGS];
    logic [W-1:0]      mem_d [NUM_REGS];
    logic [W-1:0]      rd_view [NUM_REGS];
    logic [W-1:0]      rd_data1_d, rd_data2_d, rd_data3_d;
    logic [W-1:0]      rd_data1_q, rd_data2_q, rd_data3_q;
    logic              wr_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        wr_ok   = 1'b0;
        if (!reset_i) begin
            if (state_q == StInit) begin
                mem_d[cnt_q] = '0;
                cnt_d        = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = StReady;
                end
            end else begin
                wr_ok = 1'b1;
            end
        end
        // Port B is applied after port A so it wins on a shared lane.
        if (wr_ok) begin
            for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
                if (wra_en_i && wra_mask_i[d]) begin
                    mem_d[wra_addr_i][d*DATA_W +: DATA_W] = wra_data_i[d*DATA_W +: DATA_W];
                end
                if (wrb_en_i && wrb_mask_i[d]) begin
                    mem_d[wrb_addr_i][d*DATA_W +: DATA_W] = wrb_data_i[d*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef RNS_REGFILE_BYPASS_EN
    assign rd_view = mem_d;
`else
    assign rd_view = mem_q;
`endif

    always_comb begin
        rd_data1_d = '0;
        rd_data2_d = '0;
        rd_data3_d = '0;
        if (!reset_i && state_q == StReady) begin
            rd_data1_d = rd_view[rd_addr1_i];
            rd_data2_d = rd_view[rd_addr2_i];
            rd_data3_d = rd_view[rd_addr3_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_data3_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_data3_q <= rd_data3_d;
        end
    end

    // The array itself has no reset; the clear sequence zeroes it.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rd_data1_o = rd_data1_q;
    assign rd_data2_o = rd_data2_q;
    assign rd_data3_o = rd_data3_q;
    assign busy_o     = (state_q == StInit);

endmodule

// File: tb/tb_rns_reg_file.sv
// Scoreboard bench for rns_reg_file: a driver pushes model expectations per edge, a monitor
// pops and compares them one time unit after each rising edge.
module tb_rns_reg_file;

    localparam int ND = 2;
    localparam int DW = 8;
    localparam int NR = 8;
    localparam int W  = ND * DW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [2:0]     ra1 = '0, ra2 = '0, ra3 = '0, wa_addr = '0, wb_addr = '0;
    logic           wa_en = 1'b0, wb_en = 1'b0;
    logic [W-1:0]   wa_data = '0, wb_data = '0;
    logic [ND-1:0]  wa_mask = '0, wb_mask = '0;
    logic [W-1:0]   rd1, rd2, rd3;
    logic           busy;

    rns_reg_file #(
        .NUM_DOMAINS(ND),
        .DATA_W     (DW),
        .NUM_REGS   (NR)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .rd_addr1_i(ra1),
        .rd_addr2_i(ra2),
        .rd_addr3_i(ra3),
        .rd_data1_o(rd1),
        .rd_data2_o(rd2),
        .rd_data3_o(rd3),
        .wra_en_i  (wa_en),
        .wra_addr_i(wa_addr),
        .wra_data_i(wa_data),
        .wra_mask_i(wa_mask),
        .wrb_en_i  (wb_en),
        .wrb_addr_i(wb_addr),
        .wrb_data_i(wb_data),
        .wrb_mask_i(wb_mask),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r1, r2, r3;
        logic         busy;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           passed = 0;
    int           cyc = 0;

    // Reference model: register contents as plain words, plus edges of clearing still owed.
    logic [W-1:0] m_mem [NR];
    int           init_left = 0;

    function automatic logic [W-1:0] put_lane(logic [W-1:0] word, int d, logic [W-1:0] src);
        logic [W-1:0] lane_mask;
        lane_mask = W'(((1 << DW) - 1) << (d * DW));
        return (word & ~lane_mask) | (src & lane_mask);
    endfunction

    task automatic tick();
        exp_t         e;
        logic [W-1:0] nxt [NR];
        logic         ready;
        nxt   = m_mem;
        ready = !reset && init_left == 0;
        if (ready) begin
            for (int d = 0; d < ND; d++) begin
                if (wa_en && wa_mask[d]) nxt[wa_addr] = put_lane(nxt[wa_addr], d, wa_data);
            end
            for (int d = 0; d < ND; d++) begin
                if (wb_en && wb_mask[d]) nxt[wb_addr] = put_lane(nxt[wb_addr], d, wb_data);
            end
        end
        e.r1 = '0;
        e.r2 = '0;
        e.r3 = '0;
        if (ready) begin
`ifdef RNS_REGFILE_BYPASS_EN
            e.r1 = nxt[ra1];
            e.r2 = nxt[ra2];
            e.r3 = nxt[ra3];
`else
            e.r1 = m_mem[ra1];
            e.r2 = m_mem[ra2];
            e.r3 = m_mem[ra3];
`endif
        end
        if (reset) begin
            init_left = NR;
        end else if (init_left > 0) begin
            m_mem[NR - init_left] = '0;
            init_left--;
        end else begin
            m_mem = nxt;
        end
        e.busy = (init_left > 0);
        e.cyc  = cyc;
        exp_q.push_back(e);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b0;
        wa_en = 1'b0;
        wb_en = 1'b0;
    endtask

    task automatic rd_all(input logic [2:0] a);
        ra1 = a;
        ra2 = a;
        ra3 = a;
    endtask

    task automatic wr_a(input logic [2:0] a, input logic [W-1:0] d, input logic [ND-1:0] m);
        wa_en   = 1'b1;
        wa_addr = a;
        wa_data = d;
        wa_mask = m;
    endtask

    task automatic wr_b(input logic [2:0] a, input logic [W-1:0] d, input logic [ND-1:0] m);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        wb_mask = m;
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want,
                         input int c);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s cycle %0d: got %h, expected %h", name, c, got, want);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data1", rd1, e.r1, e.cyc);
                check("rd_data2", rd2, e.r2, e.cyc);
                check("rd_data3", rd3, e.r3, e.cyc);
                check("busy", W'(busy), W'(e.busy), e.cyc);
            end
        end
    end

    task automatic reset_and_clear();
        reset = 1'b1;
        tick();
        tick();
        idle();
        for (int i = 0; i < NR; i++) tick();
    endtask

    initial begin
        // Reset, then sweep reads and poke writes while the clear runs.
        reset = 1'b1;
        tick();
        tick();
        idle();
        for (int i = 0; i < NR; i++) begin
            ra1 = 3'(i);
            ra2 = 3'(NR - 1 - i);
            ra3 = 3'(i);
            wr_a(3'd3, 16'hFFFF, 2'b11);
            wr_b(3'd3, 16'hEEEE, 2'b11);
            tick();
        end
        idle();
        for (int i = 0; i < NR; i++) begin
            ra1 = 3'(i);
            ra2 = 3'((i + 3) % NR);
            ra3 = 3'(i);
            tick();
        end
        rd_all(3'd3);
        tick();

        // Full write then read on all ports.
        wr_a(3'd2, 16'hA55A, 2'b11);
        tick();
        idle();
        rd_all(3'd2);
        tick();

        // Lane-masked writes.
        wr_a(3'd5, 16'h1122, 2'b11);
        tick();
        wr_a(3'd5, 16'h3344, 2'b01);
        tick();
        idle();
        rd_all(3'd5);
        tick();
        wr_a(3'd5, 16'h5566, 2'b10);
        tick();
        idle();
        tick();

        // Dual write priority and disjoint dual writes.
        wr_a(3'd4, 16'hAAAA, 2'b11);
        wr_b(3'd4, 16'hBBBB, 2'b01);
        tick();
        wr_a(3'd1, 16'h1111, 2'b11);
        wr_b(3'd6, 16'h6666, 2'b11);
        ra1 = 3'd4;
        tick();
        idle();
        ra1 = 3'd4;
        ra2 = 3'd1;
        ra3 = 3'd6;
        tick();

        // Same-edge write and read of one register.
        wr_a(3'd7, 16'h0101, 2'b11);
        tick();
        wr_a(3'd7, 16'hFEFE, 2'b11);
        rd_all(3'd7);
        tick();
        idle();
        tick();

        // Reset mid-clear, then reset from ready after a write.
        reset = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        reset_and_clear();
        wr_a(3'd0, 16'h7777, 2'b11);
        tick();
        idle();
        rd_all(3'd0);
        tick();
        wr_a(3'd0, 16'h1234, 2'b11);
        reset = 1'b1;
        tick();
        tick();
        idle();
        for (int i = 0; i < NR; i++) tick();
        rd_all(3'd0);
        tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 63) == 0);
            ra1     = 3'($urandom);
            ra2     = 3'($urandom);
            ra3     = 3'($urandom);
            wa_en   = 1'($urandom);
            wa_addr = 3'($urandom);
            wa_data = 16'($urandom);
            wa_mask = 2'($urandom);
            wb_en   = 1'($urandom);
            wb_addr = $urandom_range(0, 3) == 0 ? wa_addr : 3'($urandom);
            wb_data = 16'($urandom);
            wb_mask = 2'($urandom);
            tick();
        end
        idle();
        tick();

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
